// File: rtl/mmio_bus_ctrl_pkg.sv
// Shared definitions for the MMIO bus controller: access type, FSM state,
// slave address map and the value returned on an errored access.
// Ports: none (package).
package mmio_bus_ctrl_pkg;

  // Zero is a read; every non-zero encoding is a write of some width.
  typedef enum logic [2:0] {
    STORE_NONE  = 3'd0,
    STORE_BYTE  = 3'd1,
    STORE_HALF  = 3'd2,
    STORE_WORD  = 3'd3,
    STORE_DWORD = 3'd4
  } mem_store_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } bus_state_t;

  // Address map. Slave 3 is a 64 KiB window overlapping slaves 0..2, so
  // lowest-index-wins decides the overlap. Slots 4..7 use a zero mask with
  // a non-zero base: they can never match and are harmless padding.
  localparam int MMIO_MAX_SLAVES = 8;

  localparam logic [63:0] MMIO_BASE [MMIO_MAX_SLAVES] = '{
    64'h0000_0000_1000_0000,
    64'h0000_0000_1000_1000,
    64'h0000_0000_1000_2000,
    64'h0000_0000_1000_0000,
    64'h0000_0000_0000_0001,
    64'h0000_0000_0000_0001,
    64'h0000_0000_0000_0001,
    64'h0000_0000_0000_0001
  };

  localparam logic [63:0] MMIO_MASK [MMIO_MAX_SLAVES] = '{
    64'hFFFF_FFFF_FFFF_F000,
    64'hFFFF_FFFF_FFFF_F000,
    64'hFFFF_FFFF_FFFF_E000,
    64'hFFFF_FFFF_FFFF_0000,
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0000
  };

  localparam logic [63:0] ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic addr_match(input logic [63:0] addr, input int idx);
    return (addr & MMIO_MASK[idx]) == MMIO_BASE[idx];
  endfunction

endpackage

// File: rtl/mmio_bus_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: grants a lone requester, on a tie grants the
// one not granted last. Ports: clock/reset, req[1:0], update (commit grant),
// grant[1:0] (combinational, one-hot or zero).
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // Reset to "m1 granted last" so m0 wins the first tie.
  logic last_m1_q;

  always_comb begin
    grant[0] = req[0] & (~req[1] | last_m1_q);
    grant[1] = req[1] & (~req[0] | ~last_m1_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_m1_q <= 1'b1;
    end else if (update && (|grant)) begin
      last_m1_q <= grant[1];
    end
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Two-master MMIO bus controller: arbitrates, decodes to one of NUM_SLAVES
// slaves, waits for ack with a timeout, returns data or a bus error.
// Ports: m0_*/m1_* master request/response, s_* slave side, bus_error/err_addr.
module mmio_bus_ctrl
  import mmio_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int NUM_SLAVES     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        m0_valid,
  input  logic [63:0]                 m0_addr,
  input  logic [63:0]                 m0_wdata,
  input  mem_store_type_t             m0_store_type,
  output logic                        m0_ready,
  output logic [63:0]                 m0_rdata,
  input  logic                        m1_valid,
  input  logic [63:0]                 m1_addr,
  input  logic [63:0]                 m1_wdata,
  input  mem_store_type_t             m1_store_type,
  output logic                        m1_ready,
  output logic [63:0]                 m1_rdata,
  output logic [NUM_SLAVES-1:0]       s_valid,
  output logic [63:0]                 s_addr,
  output logic [63:0]                 s_wdata,
  output mem_store_type_t             s_store_type,
  input  logic [NUM_SLAVES-1:0]       s_ack,
  input  logic [NUM_SLAVES-1:0][63:0] s_rdata,
  output logic                        bus_error,
  output logic [63:0]                 err_addr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  bus_state_t             state_q, state_d;
  logic                   owner_q;        // 1: transaction belongs to m1
  logic [63:0]            addr_q, wdata_q, rdata_q, err_addr_q;
  mem_store_type_t        st_q;
  logic [NUM_SLAVES-1:0]  sel_q;
  logic [CW-1:0]          cnt_q;

  logic [1:0]             grant;
  logic                   arb_update;
  logic [63:0]            req_addr;
  logic [NUM_SLAVES-1:0]  dec_sel;
  logic                   ack_hit;
  logic                   timeout;
  logic [63:0]            ack_data;
  logic                   done;

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({m1_valid, m0_valid}),
    .update (arb_update),
    .grant  (grant)
  );

  assign req_addr = grant[1] ? m1_addr : m0_addr;

  // Walk from the top index down so the lowest matching slave is left in dec_sel.
  always_comb begin
    dec_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (addr_match(req_addr, i)) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ack_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) ack_data = s_rdata[i];
    end
  end

  // Acks from slaves other than the selected one are masked off.
  assign ack_hit = |(s_ack & sel_q);
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Next state and outputs; outputs depend on registered state only.
  always_comb begin
    state_d    = state_q;
    arb_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          arb_update = 1'b1;
          state_d    = (|dec_sel) ? REQ : ERR;
        end
      end
      REQ: begin
        if (ack_hit)      state_d = RESP;
        else if (timeout) state_d = ERR;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done         = (state_q == RESP) || (state_q == ERR);
    m0_ready     = done & ~owner_q;
    m1_ready     = done &  owner_q;
    m0_rdata     = (done & ~owner_q) ? rdata_q : '0;
    m1_rdata     = (done &  owner_q) ? rdata_q : '0;
    s_valid      = (state_q == REQ) ? sel_q : '0;
    s_addr       = addr_q;
    s_wdata      = wdata_q;
    s_store_type = st_q;
    bus_error    = (state_q == ERR);
    err_addr     = err_addr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      st_q       <= STORE_NONE;
      sel_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_update) begin
            owner_q <= grant[1];
            addr_q  <= req_addr;
            wdata_q <= grant[1] ? m1_wdata : m0_wdata;
            st_q    <= grant[1] ? m1_store_type : m0_store_type;
            sel_q   <= dec_sel;
            cnt_q   <= '0;
            if (~|dec_sel) begin
              rdata_q    <= ERR_RDATA;
              err_addr_q <= req_addr;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (ack_hit) begin
            // Writes complete with zero read data.
            rdata_q <= (st_q == STORE_NONE) ? ack_data : '0;
          end else if (timeout) begin
            rdata_q    <= ERR_RDATA;
            err_addr_q <= addr_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
